// File: rtl/fixed_softsign_grad_pkg.sv
// Shared constants and the piecewise-linear table for g(x) = 1/(1+|x|)^2.
// a[k] is g(k/2) in Q1.15. b[k] is the segment slope in g-LSB per 2^-8 of x, scaled by 2^B_SHIFT.
package fixed_softsign_grad_pkg;

  localparam int SEG_N     = 32;
  localparam int SEG_IDX_W = 5;
  localparam int SEG_T_W   = 7;
  localparam int G_W       = 16;
  localparam int B_SHIFT   = 4;

  typedef struct packed {
    logic [G_W-1:0] a;
    logic [G_W-1:0] b;
  } seg_coef_t;

  localparam seg_coef_t SEG_LUT [0:SEG_N-1] = '{
    '{16'd32768, 16'd2276}, '{16'd14564, 16'd796}, '{16'd8192, 16'd369}, '{16'd5243, 16'd200},
    '{16'd3641,  16'd121},  '{16'd2675,  16'd78},  '{16'd2048, 16'd54},  '{16'd1618, 16'd38},
    '{16'd1311,  16'd28},   '{16'd1083,  16'd22},  '{16'd910,  16'd17},  '{16'd776,  16'd13},
    '{16'd669,   16'd11},   '{16'd583,   16'd9},   '{16'd512,  16'd7},   '{16'd454,  16'd6},
    '{16'd405,   16'd5},    '{16'd363,   16'd4},   '{16'd328,  16'd4},   '{16'd297,  16'd3},
    '{16'd271,   16'd3},    '{16'd248,   16'd3},   '{16'd228,  16'd2},   '{16'd210,  16'd2},
    '{16'd194,   16'd2},    '{16'd180,   16'd2},   '{16'd167,  16'd1},   '{16'd156,  16'd1},
    '{16'd146,   16'd1},    '{16'd136,   16'd1},   '{16'd128,  16'd1},   '{16'd120,  16'd1}
  };

endpackage

// File: rtl/fixed_softsign_grad_lane.sv
// One lane of the softsign backward pass: |x| -> segment lookup -> dy*g with
// round-half-up and saturation. Three registered stages, all gated by en_i.
module fixed_softsign_grad_lane
  import fixed_softsign_grad_pkg::*;
#(
  parameter int XW = 16,
  parameter int XF = 8,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic signed [XW-1:0] x_i,
  input  logic signed [DW-1:0] dy_i,
  output logic signed [DW-1:0] dx_o
);

  localparam int AW = XW + 1;
  localparam int CW = G_W + SEG_T_W;
  localparam int PW = DW + G_W + 1;
  localparam logic signed [PW-1:0] RND  = PW'(1) << (G_W - 2);
  localparam logic signed [PW-1:0] MAXV = PW'(2 ** (DW - 1) - 1);
  localparam logic signed [PW-1:0] MINV = -MAXV - 1;

  logic signed [AW-1:0]  xs;
  logic [AW-1:0]         ax, idx_full;
  logic [XF-2:0]         t_full;
  logic [SEG_IDX_W-1:0]  idx_d, idx_q;
  logic [SEG_T_W-1:0]    t_d, t_q;
  logic                  zero_d, zero_q;
  logic signed [DW-1:0]  dy1_q, dy2_q;
  seg_coef_t             coef;
  logic [CW-1:0]         prod, corr, gdiff;
  logic [G_W-1:0]        g_d, g_q;
  logic signed [PW-1:0]  p, r;
  logic signed [DW-1:0]  dx_d, dx_q;

  // One extra bit keeps |most-negative| representable.
  always_comb begin
    xs       = {x_i[XW-1], x_i};
    ax       = xs[AW-1] ? AW'(-xs) : AW'(xs);
    idx_full = ax >> (XF - 1);
    t_full   = ax[XF-2:0];
    zero_d   = idx_full >= AW'(SEG_N);
    idx_d    = idx_full[SEG_IDX_W-1:0];
  end

  // The table slope is tabulated for a 7-bit in-segment offset.
  if (XF - 1 >= SEG_T_W) begin : g_t_trunc
    assign t_d = t_full[XF-2 -: SEG_T_W];
  end else begin : g_t_pad
    assign t_d = {t_full, {(SEG_T_W - XF + 1){1'b0}}};
  end

  always_comb begin
    coef  = SEG_LUT[idx_q];
    prod  = CW'(coef.b) * CW'(t_q);
    corr  = (prod + CW'(1 << (B_SHIFT - 1))) >> B_SHIFT;
    gdiff = CW'(coef.a) - corr;
    g_d   = '0;
    if (!zero_q && corr <= CW'(coef.a)) g_d = gdiff[G_W-1:0];
  end

  always_comb begin
    p = PW'(dy2_q) * PW'($signed({1'b0, g_q}));
    r = (p + RND) >>> (G_W - 1);
    if (r > MAXV)      dx_d = MAXV[DW-1:0];
    else if (r < MINV) dx_d = MINV[DW-1:0];
    else               dx_d = r[DW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      t_q    <= '0;
      zero_q <= 1'b0;
      dy1_q  <= '0;
      g_q    <= '0;
      dy2_q  <= '0;
      dx_q   <= '0;
    end else if (en_i) begin
      idx_q  <= idx_d;
      t_q    <= t_d;
      zero_q <= zero_d;
      dy1_q  <= dy_i;
      g_q    <= g_d;
      dy2_q  <= dy1_q;
      dx_q   <= dx_d;
    end
  end

  assign dx_o = dx_q;

endmodule

// File: rtl/fixed_softsign_grad.sv
// Softsign gradient dx = dy * 1/(1+|x|)^2 over P lanes; joins the x and dy
// streams and runs them through a 3-stage pipeline that stalls as one.
module fixed_softsign_grad
  import fixed_softsign_grad_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0       = 16,
  parameter int DATA_IN_0_PRECISION_1       = 8,
  parameter int DATA_IN_1_PRECISION_0       = 16,
  parameter int DATA_IN_1_PRECISION_1       = 8,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 8,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  localparam int P  = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1,
  localparam int XW = DATA_IN_0_PRECISION_0,
  localparam int DW = DATA_IN_1_PRECISION_0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [P-1:0][XW-1:0] data_in_0,
  input  logic                 data_in_0_valid,
  output logic                 data_in_0_ready,
  input  logic [P-1:0][DW-1:0] data_in_1,
  input  logic                 data_in_1_valid,
  output logic                 data_in_1_ready,
  output logic [P-1:0][DW-1:0] data_out_0,
  output logic                 data_out_0_valid,
  input  logic                 data_out_0_ready
);

  localparam int STAGES = 3;

  if (DATA_IN_0_PRECISION_1 < 2) begin : g_bad_xfrac
    $error("x needs at least 2 fractional bits");
  end
  if (DATA_IN_1_PRECISION_1 >= DATA_IN_1_PRECISION_0) begin : g_bad_dyfmt
    $error("dy format must keep a sign bit");
  end

  logic              en, fire;
  logic [STAGES:1]   vld_pipe_q;

  // A beat moves only when both streams offer one; neither is taken alone.
  assign en               = !vld_pipe_q[STAGES] | data_out_0_ready;
  assign data_in_0_ready  = en & data_in_1_valid;
  assign data_in_1_ready  = en & data_in_0_valid;
  assign fire             = en & data_in_0_valid & data_in_1_valid;
  assign data_out_0_valid = vld_pipe_q[STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     vld_pipe_q <= '0;
    else if (en) vld_pipe_q <= {vld_pipe_q[STAGES-1:1], fire};
  end

  for (genvar i = 0; i < P; i++) begin : g_lane
    fixed_softsign_grad_lane #(
      .XW(XW),
      .XF(DATA_IN_0_PRECISION_1),
      .DW(DW)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en_i (en),
      .x_i  (data_in_0[i]),
      .dy_i (data_in_1[i]),
      .dx_o (data_out_0[i])
    );
  end

endmodule

// File: tb/tb_fixed_softsign_grad.sv
// Scoreboard bench for fixed_softsign_grad: driver pushes expected beats from a
// real-arithmetic model of g(x); a negedge monitor pops and compares.
module tb_fixed_softsign_grad;

  localparam int P  = 8;
  localparam int XW = 16;
  localparam int DW = 16;
  typedef logic [P-1:0][DW-1:0] beat_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  beat_t data_in_0, data_in_1, data_out_0;
  logic  data_in_0_valid, data_in_0_ready;
  logic  data_in_1_valid, data_in_1_ready;
  logic  data_out_0_valid, data_out_0_ready;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  int    a_tab[32];
  int    b_tab[32];
  bit    rnd_done;

  fixed_softsign_grad #(
    .DATA_IN_0_PRECISION_0(16), .DATA_IN_0_PRECISION_1(8),
    .DATA_IN_1_PRECISION_0(16), .DATA_IN_1_PRECISION_1(8),
    .DATA_IN_0_PARALLELISM_DIM_0(8), .DATA_IN_0_PARALLELISM_DIM_1(1)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in_0(data_in_0), .data_in_0_valid(data_in_0_valid), .data_in_0_ready(data_in_0_ready),
    .data_in_1(data_in_1), .data_in_1_valid(data_in_1_valid), .data_in_1_ready(data_in_1_ready),
    .data_out_0(data_out_0), .data_out_0_valid(data_out_0_valid), .data_out_0_ready(data_out_0_ready)
  );

  initial forever #5 clk = ~clk;

  function automatic real gfn(real x);
    return 1.0 / ((1.0 + x) * (1.0 + x));
  endfunction

  // Reference: g from half-unit linear segments, dx = round-half-up(dy*g), saturated.
  function automatic logic [15:0] ref_dx(logic [15:0] x, logic [15:0] dy);
    int xi, ax, k, t, g;
    longint p, r;
    xi = int'($signed(x));
    ax = (xi < 0) ? -xi : xi;
    if (ax >= 16 * 256) g = 0;
    else begin
      k = ax / 128;
      t = ax % 128;
      g = a_tab[k] - (b_tab[k] * t + 8) / 16;
      if (g < 0) g = 0;
    end
    p = longint'($signed(dy)) * longint'(g);
    r = (p + 16384) >>> 15;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  function automatic beat_t model(beat_t x, beat_t dy);
    beat_t o;
    for (int i = 0; i < P; i++) o[i] = ref_dx(x[i], dy[i]);
    return o;
  endfunction

  function automatic beat_t splat(logic [15:0] v);
    beat_t o;
    for (int i = 0; i < P; i++) o[i] = v;
    return o;
  endfunction

  function automatic beat_t rand_x();
    beat_t o;
    for (int i = 0; i < P; i++)
      if ($urandom_range(0, 1) == 0) o[i] = 16'($urandom);
      else o[i] = 16'(int'($urandom_range(0, 10240)) - 5120);
    return o;
  endfunction

  function automatic beat_t rand_dy();
    beat_t o;
    for (int i = 0; i < P; i++) o[i] = 16'($urandom);
    return o;
  endfunction

  task automatic chk(input string name, input logic [P*DW-1:0] act, input logic [P*DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic send(input beat_t x, input beat_t dy, input beat_t e, output int waits);
    waits = 0;
    data_in_0 = x; data_in_1 = dy;
    data_in_0_valid = 1'b1; data_in_1_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (data_in_0_ready && data_in_1_ready) break;
      waits++;
      if (waits > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout: beat not accepted in 200 cycles");
        break;
      end
    end
    if (waits <= 200) exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic send_rand();
    beat_t x, dy;
    int w;
    x = rand_x(); dy = rand_dy();
    send(x, dy, model(x, dy), w);
  endtask

  task automatic idle();
    data_in_0_valid = 1'b0; data_in_1_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 500) begin @(posedge clk); n++; end
    #1;
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic latency3(input string tag);
    @(negedge clk); chk({tag, "_lat1"}, data_out_0_valid, 0);
    @(negedge clk); chk({tag, "_lat2"}, data_out_0_valid, 0);
    @(negedge clk); chk({tag, "_lat3"}, data_out_0_valid, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst && data_out_0_valid && data_out_0_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got %h with nothing expected", data_out_0);
        end else begin
          e = exp_q.pop_front();
          chk("dx_beat", data_out_0, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int w;
    beat_t hold;
    for (int k = 0; k < 32; k++) begin
      a_tab[k] = $rtoi(gfn(k / 2.0) * 32768.0 + 0.5);
      b_tab[k] = $rtoi((gfn(k / 2.0) - gfn((k + 1) / 2.0)) * 32768.0 * 16.0 / 128.0 + 0.5);
    end
    data_in_0 = '0; data_in_1 = '0;
    data_in_0_valid = 1'b0; data_in_1_valid = 1'b1;
    data_out_0_ready = 1'b1;

    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", data_out_0_valid, 0);
    chk("rst_out_data", data_out_0, 0);
    chk("rst_in0_ready", data_in_0_ready, 1);
    chk("rst_in1_ready", data_in_1_ready, 0);
    data_in_1_valid = 1'b0;
    rst = 1'b0;

    send(splat(16'h0000), splat(16'h0100), splat(16'h0100), w);
    idle();
    latency3("first");

    send(splat(16'hFF00), splat(16'h0200), splat(16'h0080), w);
    send(splat(16'h0100), splat(16'hFE00), splat(16'hFF80), w);
    send(splat(16'h1000), splat(16'h7FFF), splat(16'h0000), w);
    send(splat(16'h8000), splat(16'h0001), splat(16'h0000), w);
    idle();
    drain();

    // x offered alone must not be consumed
    data_in_0 = splat(16'h0180); data_in_0_valid = 1'b1; data_in_1_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("join_in0_ready", data_in_0_ready, 0);
    end
    @(posedge clk); #1;
    send(splat(16'h0180), splat(16'h0100), model(splat(16'h0180), splat(16'h0100)), w);
    chk("join_accept_wait", w, 0);
    idle();
    drain();

    fork
      begin
        for (int i = 0; i < 6; i++) send_rand();
        idle();
      end
      begin
        data_out_0_ready = 1'b0;
        for (int c = 1; c <= 5; c++) begin
          @(negedge clk); #1;
          if (c >= 4) begin
            chk("stall_in0_ready", data_in_0_ready, 0);
            chk("stall_in1_ready", data_in_1_ready, 0);
            chk("stall_out_valid", data_out_0_valid, 1);
            if (c == 4) hold = data_out_0;
            else chk("stall_out_hold", data_out_0, hold);
          end
        end
        @(posedge clk); #1;
        data_out_0_ready = 1'b1;
      end
    join
    drain();

    for (int i = 0; i < 3; i++) send_rand();
    idle();
    chk("prerst_valid", data_out_0_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", data_out_0_valid, 0);
    chk("async_rst_data", data_out_0, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    send(splat(16'hFF00), splat(16'h0200), splat(16'h0080), w);
    chk("post_rst_wait", w, 0);
    idle();
    latency3("postrst");
    drain();

    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin idle(); @(posedge clk); #1; end
          send_rand();
        end
        idle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          data_out_0_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        data_out_0_ready = 1'b1;
      end
    join
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
